cost_arb: RTL and testbench

COST_ARB -- requirements
Module: cost_arb

---
 rtl/cost_arb.sv | 111 +++++++++++
 tb/tb_cost_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cost_arb.sv
// Two-requester 8-beat burst arbiter with a 2-cycle cost-table lookup pipeline (grant -> W/J -> RDATA).
// Requesters hold REQx until GNTx is seen; define COST_ARB_FIXED_PRIO_EN for requester-0 priority on ties.
module cost_arb (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic [2:0] W0,
  input  logic [2:0] J0,
  output logic       GNT0,
  input  logic       REQ1,
  input  logic [2:0] W1,
  input  logic [2:0] J1,
  output logic       GNT1,
  output logic [2:0] W,
  output logic [2:0] J,
  input  logic [6:0] Cost,
  output logic [6:0] RDATA,
  output logic       RVLD0,
  output logic       RVLD1,
  output logic       BUSY
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state, state_nxt;
  logic [2:0] beat, beat_nxt;
  logic       last, last_nxt;
  logic       any_req;
  logic       pick;
  logic       a_vld;
  logic       a_own;

  assign any_req = REQ0 | REQ1;

  // last doubles as the owner of the burst in progress
`ifdef COST_ARB_FIXED_PRIO_EN
  assign pick = ~REQ0;
`else
  assign pick = (REQ0 & REQ1) ? ~last : REQ1;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      beat  <= 3'd0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BURST;
          beat_nxt  = 3'd0;
          last_nxt  = pick;
        end
      end
      BURST: begin
        if (beat == 3'd7) begin
          beat_nxt = 3'd0;
          if (any_req) begin
            last_nxt = pick;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          beat_nxt = beat + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == BURST);
  assign GNT0 = BUSY & ~last;
  assign GNT1 = BUSY & last;

  // Stage A: table address; stage B: returned cost. Owner travels alongside so return order follows grant order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      W     <= 3'd0;
      J     <= 3'd0;
      a_vld <= 1'b0;
      a_own <= 1'b0;
      RDATA <= 7'd0;
      RVLD0 <= 1'b0;
      RVLD1 <= 1'b0;
    end else begin
      a_vld <= BUSY;
      a_own <= last;
      if (BUSY) begin
        W <= last ? W1 : W0;
        J <= last ? J1 : J0;
      end
      RVLD0 <= a_vld & ~a_own;
      RVLD1 <= a_vld & a_own;
      if (a_vld) begin
        RDATA <= Cost;
      end
    end
  end

endmodule

// File: tb/tb_cost_arb.sv
// Bench for cost_arb: reference-vector table, directed corner sequences and a randomized run against a burst-level model.
module tb_cost_arb;

`ifdef COST_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [2:0] w0, j0, w1, j1;
  logic       gnt0, gnt1;
  logic [2:0] w, j;
  logic [6:0] cost;
  logic [6:0] rdata;
  logic       rvld0, rvld1, busy;

  logic [6:0] tbl [64];
  assign cost = tbl[{w, j}];

  cost_arb dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .W0(w0), .J0(j0), .GNT0(gnt0),
    .REQ1(req1), .W1(w1), .J1(j1), .GNT1(gnt1),
    .W(w), .J(j), .Cost(cost),
    .RDATA(rdata), .RVLD0(rvld0), .RVLD1(rvld1), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Burst-level model: remaining-beat countdown plus a queue of returns keyed by due cycle.
  typedef struct { int due; bit who; logic [6:0] d; } ret_t;
  ret_t       rq[$];
  int         m_cnt  = 0;
  bit         m_own  = 1'b0;
  bit         m_last = 1'b1;
  logic       e_gnt0, e_gnt1, e_busy, e_rv0, e_rv1;
  logic [6:0] e_rd;
  logic [2:0] e_w, e_j;

  task automatic model_step();
    ret_t r;
    logic [5:0] addr;
    cyc_n++;
    if (!rst) begin
      m_cnt  = 0;
      m_last = 1'b1;
      rq.delete();
      e_w = 3'd0; e_j = 3'd0; e_rd = 7'd0;
      e_rv0 = 1'b0; e_rv1 = 1'b0;
    end else begin
      if (m_cnt > 0) begin
        addr = m_own ? {w1, j1} : {w0, j0};
        e_w = addr[5:3];
        e_j = addr[2:0];
        r.due = cyc_n + 1;
        r.who = m_own;
        r.d   = tbl[addr];
        rq.push_back(r);
        m_cnt--;
      end
      if (m_cnt == 0 && (req0 || req1)) begin
        if (req0 && req1) m_own = FIXED ? 1'b0 : !m_last;
        else              m_own = req1;
        m_last = m_own;
        m_cnt  = 8;
      end
      e_rv0 = 1'b0;
      e_rv1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc_n) begin
        r = rq.pop_front();
        e_rd  = r.d;
        e_rv0 = !r.who;
        e_rv1 = r.who;
      end
    end
    e_busy = (m_cnt > 0);
    e_gnt0 = e_busy && !m_own;
    e_gnt1 = e_busy && m_own;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("gnt0", gnt0, e_gnt0);
    chk("gnt1", gnt1, e_gnt1);
    chk("busy", busy, e_busy);
    chk("rvld0", rvld0, e_rv0);
    chk("rvld1", rvld1, e_rv1);
    chk("rdata", rdata, e_rd);
    chk("w", w, e_w);
    chk("j", j, e_j);
    if (rvld0 && rvld1) chk("rvld_overlap", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       rst, r0;
    logic [2:0] w0, j0;
    logic       g0, bz, rv0;
    logic [6:0] rd;
    logic [2:0] ew, ej;
  } vec_t;
  vec_t vt[12];

  int cnt_g, cnt_r;

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    w0 = 3'd0; j0 = 3'd0; w1 = 3'd0; j1 = 3'd0;
    for (int a = 0; a < 64; a++) tbl[a] = 7'((a * 37 + 11) & 127);

    // Single requester-0 burst, address stepping (7,0)..(0,7); each row lists the outputs seen after its edge.
    for (int r = 0; r < 12; r++) begin
      vt[r].rst = (r != 0);
      vt[r].r0  = (r == 1);
      vt[r].w0  = (r >= 2 && r <= 9) ? 3'(7 - (r - 2)) : 3'd0;
      vt[r].j0  = (r >= 2 && r <= 9) ? 3'(r - 2) : 3'd0;
      vt[r].g0  = (r >= 1 && r <= 8);
      vt[r].bz  = (r >= 1 && r <= 8);
      vt[r].rv0 = (r >= 3 && r <= 10);
      vt[r].ew  = (r < 2) ? 3'd0 : (r <= 9) ? 3'(7 - (r - 2)) : 3'd0;
      vt[r].ej  = (r < 2) ? 3'd0 : (r <= 9) ? 3'(r - 2) : 3'd7;
      vt[r].rd  = (r < 3) ? 7'd0 : (r <= 10) ? tbl[{3'(7 - (r - 3)), 3'(r - 3)}] : tbl[7];
    end
    for (int r = 0; r < 12; r++) begin
      rst = vt[r].rst; req0 = vt[r].r0; w0 = vt[r].w0; j0 = vt[r].j0;
      cyc();
      chk($sformatf("vec%0d_gnt0", r), gnt0, vt[r].g0);
      chk($sformatf("vec%0d_gnt1", r), gnt1, 0);
      chk($sformatf("vec%0d_busy", r), busy, vt[r].bz);
      chk($sformatf("vec%0d_rvld0", r), rvld0, vt[r].rv0);
      chk($sformatf("vec%0d_rvld1", r), rvld1, 0);
      chk($sformatf("vec%0d_rdata", r), rdata, vt[r].rd);
      chk($sformatf("vec%0d_w", r), w, vt[r].ew);
      chk($sformatf("vec%0d_j", r), j, vt[r].ej);
    end

    // Both requesting: back-to-back bursts, round-robin (or requester 0 only with fixed priority).
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cyc();
      chk($sformatf("tie_burst%0d_gnt1", b), gnt1, FIXED ? 0 : (b % 2));
      chk($sformatf("tie_burst%0d_busy", b), busy, 1);
      for (int k = 0; k < 7; k++) cyc();
    end
    req0 = 1'b0;
    cyc();
    chk("after_drop_gnt1", gnt1, 1);
    req1 = 1'b0;
    for (int k = 0; k < 12; k++) cyc();

    // Requester 1 drops after two beats: burst still completes.
    do_reset();
    req1 = 1'b1;
    cnt_g = 0; cnt_r = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (gnt1) cnt_g++;
      if (rvld1) cnt_r++;
      if (cnt_g == 2) req1 = 1'b0;
    end
    chk("drop_gnt1_beats", cnt_g, 8);
    chk("drop_rvld1_pulses", cnt_r, 8);

    // Reset at beat 4, then a clean burst for requester 1.
    do_reset();
    req0 = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    req0 = 1'b0;
    rst = 1'b0;
    cyc();
    chk("midrst_gnt0", gnt0, 0);
    chk("midrst_gnt1", gnt1, 0);
    chk("midrst_rvld0", rvld0, 0);
    chk("midrst_rvld1", rvld1, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1; req1 = 1'b1;
    cyc();
    chk("release_rvld0", rvld0, 0);
    chk("release_rvld1", rvld1, 0);
    chk("release_gnt1", gnt1, 1);
    req1 = 1'b0;
    cnt_g = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (gnt1) cnt_g++;
    end
    chk("release_gnt1_beats", cnt_g, 8);

    // Saturated table entry at (3,5) returns 127 two cycles after its grant.
    tbl[29] = 7'd127;
    do_reset();
    req0 = 1'b1; w0 = 3'd1; j0 = 3'd1;
    cyc();
    req0 = 1'b0; w0 = 3'd3; j0 = 3'd5;
    cyc();
    chk("max_w", w, 3);
    chk("max_j", j, 5);
    w0 = 3'd0; j0 = 3'd0;
    cyc();
    chk("max_rvld0", rvld0, 1);
    chk("max_rdata", rdata, 127);
    for (int k = 0; k < 10; k++) cyc();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rst  = ($urandom_range(0, 255) != 0);
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      w0 = 3'($urandom); j0 = 3'($urandom);
      w1 = 3'($urandom); j1 = 3'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
